// File: rtl/axi_cpl_resp_push.sv
// ============================================================================
// axi_cpl_resp_push : completion-side push engine, tag lookup to B/R FIFO
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_cpl_resp_push #(
  parameter int ID_WIDTH          = 8,
  parameter int TAG_WIDTH         = 8,
  parameter int DATA_WIDTH        = 1024,
  parameter int B_FIFO_DATA_WIDTH = 10,
  parameter int R_FIFO_DATA_WIDTH = 1034
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         cpl_valid,
  output logic                         cpl_ready,
  input  logic [95:0]                  cpl_hdr,
  input  logic [DATA_WIDTH-1:0]        cpl_data,
  output logic [TAG_WIDTH-1:0]         rec_rd_addr,
  input  logic [ID_WIDTH:0]            rec_rd_data,
  input  logic                         rec_rd_vld,
  output logic                         rec_free,
  output logic [TAG_WIDTH-1:0]         rec_free_addr,
  output logic                         b_push,
  output logic [B_FIFO_DATA_WIDTH-1:0] b_wdata,
  input  logic                         b_full,
  output logic                         r_push,
  output logic [R_FIFO_DATA_WIDTH-1:0] r_wdata,
  input  logic                         r_full,
  output logic                         unexp_cpl
);

  localparam int NUM_DW = DATA_WIDTH / 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] B_PUSH = 2'd2;
  localparam logic [1:0] R_PUSH = 2'd3;

  localparam logic [2:0] FMT_3DW_DATA = 3'b010;
  localparam logic [2:0] ST_SC        = 3'b000;
  localparam logic [2:0] ST_UR        = 3'b001;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;

  logic [1:0]                   state_q, state_d;
  logic [2:0]                   fmt_q, fmt_d;
  logic                         ep_q, ep_d;
  logic [9:0]                   len_q, len_d;
  logic [2:0]                   status_q, status_d;
  logic [DATA_WIDTH-1:0]        data_q, data_d;
  logic [TAG_WIDTH-1:0]         rec_rd_addr_q, rec_rd_addr_d;
  logic [B_FIFO_DATA_WIDTH-1:0] b_wdata_q, b_wdata_d;
  logic [R_FIFO_DATA_WIDTH-1:0] r_wdata_q, r_wdata_d;

  logic                         data_ok;
  logic [1:0]                   cpl_resp;
  logic [1:0]                   rd_resp;
  logic [DATA_WIDTH-1:0]        masked_data;
  logic                         unused_hdr;

  // Only the decoded header fields are kept; the rest of the header is don't-care here.
  assign unused_hdr = ^{cpl_hdr[92:79], cpl_hdr[77:74], cpl_hdr[63:48],
                        cpl_hdr[44:16], cpl_hdr[7:0]};

  assign cpl_resp = (status_q == ST_UR)              ? RESP_DECERR :
                    ((status_q == ST_SC) && !ep_q)   ? RESP_OKAY   : RESP_SLVERR;

  assign data_ok = (fmt_q == FMT_3DW_DATA) && (len_q != 10'd0) &&
                   (len_q <= 10'(NUM_DW));

  // A malformed read payload can never be OKAY, but a UR status still wins.
  assign rd_resp = (data_ok || (cpl_resp == RESP_DECERR)) ? cpl_resp : RESP_SLVERR;

  for (genvar i = 0; i < NUM_DW; i++) begin : g_dw_mask
    assign masked_data[i*32 +: 32] = (data_ok && (len_q > 10'(i))) ?
                                     data_q[i*32 +: 32] : 32'd0;
  end

  always_comb begin
    state_d       = state_q;
    fmt_d         = fmt_q;
    ep_d          = ep_q;
    len_d         = len_q;
    status_d      = status_q;
    data_d        = data_q;
    rec_rd_addr_d = rec_rd_addr_q;
    b_wdata_d     = b_wdata_q;
    r_wdata_d     = r_wdata_q;
    case (state_q)
      IDLE: begin
        if (cpl_valid) begin
          fmt_d         = cpl_hdr[95:93];
          ep_d          = cpl_hdr[78];
          len_d         = cpl_hdr[73:64];
          status_d      = cpl_hdr[47:45];
          data_d        = cpl_data;
          rec_rd_addr_d = cpl_hdr[8 +: TAG_WIDTH];
          state_d       = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!rec_rd_vld) begin
          state_d = IDLE;
        end else if (rec_rd_data[ID_WIDTH]) begin
          b_wdata_d = {rec_rd_data[ID_WIDTH-1:0], cpl_resp};
          state_d   = B_PUSH;
        end else begin
          r_wdata_d = {rec_rd_data[ID_WIDTH-1:0], rd_resp, masked_data};
          state_d   = R_PUSH;
        end
      end
      B_PUSH: begin
        if (!b_full) state_d = IDLE;
      end
      R_PUSH: begin
        if (!r_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= IDLE;
      fmt_q         <= '0;
      ep_q          <= 1'b0;
      len_q         <= '0;
      status_q      <= '0;
      data_q        <= '0;
      rec_rd_addr_q <= '0;
      b_wdata_q     <= '0;
      r_wdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      fmt_q         <= fmt_d;
      ep_q          <= ep_d;
      len_q         <= len_d;
      status_q      <= status_d;
      data_q        <= data_d;
      rec_rd_addr_q <= rec_rd_addr_d;
      b_wdata_q     <= b_wdata_d;
      r_wdata_q     <= r_wdata_d;
    end
  end

  assign cpl_ready     = (state_q == IDLE);
  assign rec_rd_addr   = rec_rd_addr_q;
  assign b_push        = (state_q == B_PUSH) && !b_full;
  assign r_push        = (state_q == R_PUSH) && !r_full;
  assign b_wdata       = b_wdata_q;
  assign r_wdata       = r_wdata_q;
  assign rec_free      = b_push || r_push;
  assign rec_free_addr = rec_rd_addr_q;
  assign unexp_cpl     = (state_q == LOOKUP) && !rec_rd_vld;

endmodule

`default_nettype wire

// File: tb/tb_axi_cpl_resp_push.sv
// ============================================================================
// tb_axi_cpl_resp_push : scoreboard bench for the completion push engine
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_cpl_resp_push;

  logic           clk;
  logic           rst;
  logic           cpl_valid;
  logic           cpl_ready;
  logic [95:0]    cpl_hdr;
  logic [1023:0]  cpl_data;
  logic [7:0]     rec_rd_addr;
  logic [8:0]     rec_rd_data;
  logic           rec_rd_vld;
  logic           rec_free;
  logic [7:0]     rec_free_addr;
  logic           b_push;
  logic [9:0]     b_wdata;
  logic           b_full;
  logic           r_push;
  logic [1033:0]  r_wdata;
  logic           r_full;
  logic           unexp_cpl;

  axi_cpl_resp_push dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .cpl_valid     (cpl_valid),
    .cpl_ready     (cpl_ready),
    .cpl_hdr       (cpl_hdr),
    .cpl_data      (cpl_data),
    .rec_rd_addr   (rec_rd_addr),
    .rec_rd_data   (rec_rd_data),
    .rec_rd_vld    (rec_rd_vld),
    .rec_free      (rec_free),
    .rec_free_addr (rec_free_addr),
    .b_push        (b_push),
    .b_wdata       (b_wdata),
    .b_full        (b_full),
    .r_push        (r_push),
    .r_wdata       (r_wdata),
    .r_full        (r_full),
    .unexp_cpl     (unexp_cpl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Recorder model: {is_write, ID} per tag plus in-use flag
  logic [8:0] rec_mem [256];
  logic       rec_vld_mem [256];
  assign rec_rd_data = rec_mem[rec_rd_addr];
  assign rec_rd_vld  = rec_vld_mem[rec_rd_addr];

  typedef struct {
    bit            is_b;
    logic [7:0]    tag;
    logic [7:0]    id;
    logic [1:0]    resp;
    logic [1023:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   push_cnt = 0;
  int   free_cnt = 0;
  int   unexp_cnt = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Independent model of the expected FIFO entry
  function automatic exp_t model(input logic [7:0] tag, input logic [2:0] fmt, input logic ep,
                                 input logic [9:0] len, input logic [2:0] st,
                                 input logic [1023:0] data);
    exp_t e;
    logic [1:0] resp;
    bit ok;
    e.is_b = rec_mem[tag][8];
    e.tag  = tag;
    e.id   = rec_mem[tag][7:0];
    if (st == 3'b001)             resp = 2'b11;
    else if (st == 3'b000 && !ep) resp = 2'b00;
    else                          resp = 2'b10;
    ok = (fmt == 3'b010) && (len >= 10'd1) && (len <= 10'd32);
    e.rdata = '0;
    if (e.is_b) begin
      e.resp = resp;
    end else begin
      e.resp = (ok || resp == 2'b11) ? resp : 2'b10;
      for (int i = 0; i < 32; i++)
        if (ok && i < int'(len)) e.rdata[i*32 +: 32] = data[i*32 +: 32];
    end
    return e;
  endfunction

  task automatic send_cpl(input logic [7:0] tag, input logic [2:0] fmt, input logic ep,
                          input logic [9:0] len, input logic [2:0] st,
                          input logic [1023:0] data, input bit expect_push);
    logic [95:0] h;
    bit ok;
    h = '0;
    h[95:93] = fmt;
    h[78]    = ep;
    h[73:64] = len;
    h[47:45] = st;
    h[31:16] = 16'hBEEF;
    h[15:8]  = tag;
    if (expect_push) sb.push_back(model(tag, fmt, ep, len, st, data));
    cpl_hdr   = h;
    cpl_data  = data;
    cpl_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpl_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 128'(ok), 128'(1'b1));
    @(posedge clk);
    #1 cpl_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every FIFO push
  always @(negedge clk) begin
    if (!rst) begin
      if (unexp_cpl) unexp_cnt++;
      if (rec_free)  free_cnt++;
      if (b_push || r_push) begin
        exp_t e;
        push_cnt++;
        chk("one_push", 128'(b_push & r_push), 128'(1'b0));
        if (sb.size() == 0) begin
          chk("sb_underflow", 128'(1'b1), 128'(1'b0));
        end else begin
          e = sb.pop_front();
          chk("push_kind", 128'(b_push), 128'(e.is_b));
          if (e.is_b) begin
            chk("b_wdata", 128'(b_wdata), 128'({e.id, e.resp}));
          end else begin
            chk("rid", 128'(r_wdata[1033:1026]), 128'(e.id));
            chk("rresp", 128'(r_wdata[1025:1024]), 128'(e.resp));
            for (int k = 0; k < 8; k++)
              chk($sformatf("rdata%0d", k), r_wdata[k*128 +: 128], e.rdata[k*128 +: 128]);
          end
          chk("free", 128'(rec_free), 128'(1'b1));
          chk("free_addr", 128'(rec_free_addr), 128'(e.tag));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  logic [1023:0] pat;
  int p0, f0, u0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      rec_mem[i]     = '0;
      rec_vld_mem[i] = 1'b0;
    end
    rec_mem[8'h05] = {1'b0, 8'h3A}; rec_vld_mem[8'h05] = 1'b1;
    rec_mem[8'h10] = {1'b1, 8'h07}; rec_vld_mem[8'h10] = 1'b1;
    rec_mem[8'h11] = {1'b1, 8'h42}; rec_vld_mem[8'h11] = 1'b1;
    rec_mem[8'h20] = {1'b0, 8'h5C}; rec_vld_mem[8'h20] = 1'b1;
    rec_mem[8'h30] = {1'b0, 8'h99}; rec_vld_mem[8'h30] = 1'b1;
    rec_mem[8'h31] = {1'b0, 8'h11}; rec_vld_mem[8'h31] = 1'b1;
    for (int i = 0; i < 32; i++) pat[i*32 +: 32] = 32'hA5C3_0000 + 32'(i);

    rst = 1'b1; cpl_valid = 1'b0; cpl_hdr = '0; cpl_data = '0;
    b_full = 1'b0; r_full = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(cpl_ready), 128'(1'b1));
    chk("rst_bpush", 128'(b_push), 128'(1'b0));
    chk("rst_rpush", 128'(r_push), 128'(1'b0));
    chk("rst_free", 128'(rec_free), 128'(1'b0));
    chk("rst_unexp", 128'(unexp_cpl), 128'(1'b0));
    chk("rst_rdaddr", 128'(rec_rd_addr), 128'(0));
    chk("rst_wdata", 128'(|{b_wdata, r_wdata, rec_free_addr}), 128'(1'b0));

    // Read success with two-cycle latency
    wait_cyc(1);
    send_cpl(8'h05, 3'b010, 1'b0, 10'd4, 3'b000, pat, 1'b1);
    @(negedge clk);
    chk("lat_n1_rpush", 128'(r_push), 128'(1'b0));
    @(negedge clk);
    chk("lat_n2_rpush", 128'(r_push), 128'(1'b1));
    wait_cyc(2);

    // Write response with UR status
    send_cpl(8'h10, 3'b000, 1'b0, 10'd0, 3'b001, '0, 1'b1);
    wait_cyc(3);
    // CplD for a write tag: payload ignored, SC -> OKAY
    send_cpl(8'h10, 3'b010, 1'b0, 10'd8, 3'b000, pat, 1'b1);
    wait_cyc(3);

    // Backpressure on the B FIFO
    b_full = 1'b1;
    p0 = push_cnt; f0 = free_cnt;
    send_cpl(8'h11, 3'b000, 1'b0, 10'd0, 3'b000, '0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bpush", 128'(b_push), 128'(1'b0));
      chk("bp_ready", 128'(cpl_ready), 128'(1'b0));
      chk("bp_free", 128'(rec_free), 128'(1'b0));
      chk("bp_wdata", 128'(b_wdata), 128'({8'h42, 2'b00}));
    end
    @(posedge clk);
    #1 b_full = 1'b0;
    wait_cyc(4);
    chk("bp_push_once", 128'(push_cnt - p0), 128'(1));
    chk("bp_free_once", 128'(free_cnt - f0), 128'(1));

    // Unexpected tag
    p0 = push_cnt; f0 = free_cnt; u0 = unexp_cnt;
    send_cpl(8'h22, 3'b010, 1'b0, 10'd1, 3'b000, pat, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("unexp_ready", 128'(cpl_ready), 128'(1'b1));
    wait_cyc(3);
    chk("unexp_pulse", 128'(unexp_cnt - u0), 128'(1));
    chk("unexp_nopush", 128'(push_cnt - p0), 128'(0));
    chk("unexp_nofree", 128'(free_cnt - f0), 128'(0));

    // Error reads and length boundaries
    send_cpl(8'h20, 3'b000, 1'b0, 10'd4, 3'b100, pat, 1'b1);
    wait_cyc(3);
    send_cpl(8'h20, 3'b010, 1'b1, 10'd4, 3'b000, pat, 1'b1);
    wait_cyc(3);
    send_cpl(8'h20, 3'b010, 1'b0, 10'd32, 3'b000, pat, 1'b1);
    wait_cyc(3);
    send_cpl(8'h20, 3'b010, 1'b0, 10'd33, 3'b000, pat, 1'b1);
    wait_cyc(3);
    send_cpl(8'h20, 3'b010, 1'b0, 10'd0, 3'b000, pat, 1'b1);
    wait_cyc(3);
    send_cpl(8'h20, 3'b000, 1'b0, 10'd0, 3'b001, pat, 1'b1);
    wait_cyc(3);
    send_cpl(8'h20, 3'b010, 1'b0, 10'd1, 3'b010, pat, 1'b1);
    wait_cyc(3);

    // Reset while stalled in R_PUSH
    r_full = 1'b1;
    send_cpl(8'h30, 3'b010, 1'b0, 10'd2, 3'b000, pat, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    r_full = 1'b0;
    void'(sb.pop_back());
    p0 = push_cnt; f0 = free_cnt;
    @(negedge clk);
    chk("mid_rst_ready", 128'(cpl_ready), 128'(1'b1));
    chk("mid_rst_rpush", 128'(r_push), 128'(1'b0));
    chk("mid_rst_free", 128'(rec_free), 128'(1'b0));
    chk("mid_rst_rwdata", 128'(|r_wdata), 128'(1'b0));
    chk("mid_rst_rdaddr", 128'(rec_rd_addr), 128'(0));
    wait_cyc(4);
    chk("mid_rst_nopush", 128'(push_cnt - p0), 128'(0));
    chk("mid_rst_nofree", 128'(free_cnt - f0), 128'(0));
    send_cpl(8'h31, 3'b010, 1'b0, 10'd3, 3'b000, pat, 1'b1);
    wait_cyc(5);

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
